// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared defaults, FSM state type and clog2 helper for the TDC back-end
package tdc_pkg;

    localparam int TDC_CNT_W = 7;
    localparam int TDC_NPH   = 16;
    localparam int TDC_ERR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } tdc_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// rtl/tdc_therm_decode.sv - cyclic thermometer tap snapshot to fine edge index with bubble flag
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int  NPH  = TDC_NPH,
    localparam int PH_W = clog2(2 * NPH)
) (
    input  logic [NPH-1:0]  ph,
    output logic [PH_W-1:0] idx,
    output logic            bubble
);

    int              n_tr;
    logic [PH_W-1:0] edge_idx;

    // The tap NPH-1 -> tap 0 wrap is not inspected; a clean snapshot has at most one edge.
    always_comb begin
        n_tr     = 0;
        edge_idx = '0;
        for (int j = 1; j < NPH; j++) begin
            if (ph[j-1] != ph[j]) begin
                n_tr     = n_tr + 1;
                edge_idx = ph[j-1] ? PH_W'(j - 1) : PH_W'(j - 1 + NPH);
            end
        end
        bubble = (n_tr > 1);
        if (n_tr == 0) begin
            idx = ph[0] ? PH_W'(NPH - 1) : PH_W'(2 * NPH - 1);
        end else begin
            idx = edge_idx;
        end
    end

endmodule

// File: rtl/tdc_digital_pipe.sv
// rtl/tdc_digital_pipe.sv - ADPLL TDC back-end: sample, decode, differential/absolute word
module tdc_digital_pipe
    import tdc_pkg::*;
#(
    parameter int  CNT_W = TDC_CNT_W,
    parameter int  NPH   = TDC_NPH,
    parameter int  ERR_W = TDC_ERR_W,
    localparam int PH_W  = clog2(2 * NPH),
    localparam int OUT_W = CNT_W + PH_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] counter_in,
    input  logic [NPH-1:0]   phase_in,
    output logic [OUT_W-1:0] tdc_word,
    output logic             valid_o,
    output logic             bubble_o,
    output logic [ERR_W-1:0] err_cnt
);

    logic [CNT_W-1:0] cnt_s;
    logic [NPH-1:0]   ph_s;
    logic             s1_vld;

    tdc_state_e       state, state_nx;
    logic             prime, emit;

    logic [CNT_W-1:0] cnt_last;
    logic [PH_W-1:0]  idx_last;
    logic             prime_bub;

    logic [PH_W-1:0]  dec_idx;
    logic             dec_bubble;
    logic [CNT_W-1:0] cnt_aux;
    logic [CNT_W-1:0] cnt_diff;
    logic [PH_W-1:0]  idx_use;
    logic [OUT_W-1:0] word_diff;
    logic [OUT_W-1:0] word_abs;

    tdc_therm_decode #(.NPH(NPH)) u_decode (
        .ph     (ph_s),
        .idx    (dec_idx),
        .bubble (dec_bubble)
    );

    // A set tap 0 means the DCO edge landed after the counter update; pull the count back by one.
    assign cnt_aux   = cnt_s - CNT_W'(ph_s[0]);
    assign idx_use   = dec_bubble ? idx_last : dec_idx;
    assign cnt_diff  = cnt_last - cnt_aux;
    assign word_diff = {cnt_diff, {PH_W{1'b0}}} + OUT_W'(idx_use) - OUT_W'(idx_last);
    assign word_abs  = {cnt_aux, idx_use};

    always_comb begin
        state_nx = state;
        prime    = 1'b0;
        emit     = 1'b0;
        if (s1_vld) begin
            case (state)
                IDLE: begin
                    prime    = 1'b1;
                    state_nx = PRIME;
                end
                PRIME, RUN: begin
                    emit     = 1'b1;
                    state_nx = RUN;
                end
                default: state_nx = IDLE;
            endcase
        end
        // Dropping en forces a re-prime so no word ever spans a sampling gap.
        if (!en) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_s     <= '0;
            ph_s      <= '0;
            s1_vld    <= 1'b0;
            state     <= IDLE;
            cnt_last  <= '0;
            idx_last  <= '0;
            prime_bub <= 1'b0;
            tdc_word  <= '0;
            valid_o   <= 1'b0;
            bubble_o  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            s1_vld <= en;
            if (en) begin
                cnt_s <= counter_in;
                ph_s  <= phase_in;
            end
            state   <= state_nx;
            valid_o <= emit;
            if (s1_vld) begin
                cnt_last <= cnt_aux;
                if (dec_bubble && err_cnt != {ERR_W{1'b1}}) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
            if (prime) begin
                idx_last  <= dec_bubble ? '0 : dec_idx;
                prime_bub <= dec_bubble;
            end
            if (emit) begin
                idx_last  <= idx_use;
                tdc_word  <= mode ? word_abs : word_diff;
                bubble_o  <= dec_bubble | prime_bub;
                prime_bub <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdc_digital_pipe.sv
// tb/tb_tdc_digital_pipe.sv - self-checking bench for tdc_digital_pipe with a sample-level reference model
module tb_tdc_digital_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [6:0]  counter_in;
    logic [15:0] phase_in;
    logic [11:0] tdc_word;
    logic        valid_o;
    logic        bubble_o;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model: one pending sample, prime flag, last values, expected outputs
    bit          p_vld;
    int          p_cnt;
    logic [15:0] p_ph;
    bit          m_primed;
    int          m_last_cnt, m_last_idx;
    bit          m_pbub;
    int          m_err;
    bit          e_valid;
    int          e_word;
    bit          e_bub;

    tdc_digital_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .counter_in (counter_in),
        .phase_in   (phase_in),
        .tdc_word   (tdc_word),
        .valid_o    (valid_o),
        .bubble_o   (bubble_o),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // A clean cyclic snapshot is a run of ones (tap 0 set) or zeros (tap 0 clear) starting at tap 0.
    function automatic void ref_decode(input logic [15:0] p, output int idx, output bit bub);
        int          ones;
        int          run;
        logic [31:0] mask;
        ones = $countones(p);
        if (p[0]) begin
            run  = ones;
            mask = (32'd1 << run) - 32'd1;
            idx  = run - 1;
            bub  = (p != mask[15:0]);
        end else begin
            run  = 16 - ones;
            mask = (32'd1 << run) - 32'd1;
            idx  = run - 1 + 16;
            bub  = (p != ~mask[15:0]);
        end
    endfunction

    function automatic void model_reset();
        p_vld = 0; p_cnt = 0; p_ph = '0; m_primed = 0;
        m_last_cnt = 0; m_last_idx = 0; m_pbub = 0; m_err = 0;
        e_valid = 0; e_word = 0; e_bub = 0;
    endfunction

    function automatic void model_edge(input bit e, input bit m, input int c, input logic [15:0] p);
        int aux, idx, use_idx;
        bit bub;
        e_valid = 0;
        if (p_vld) begin
            aux = (p_cnt - int'(p_ph[0])) & 127;
            ref_decode(p_ph, idx, bub);
            if (bub && m_err < 255) m_err++;
            if (!m_primed) begin
                m_primed   = 1;
                m_last_cnt = aux;
                m_last_idx = bub ? 0 : idx;
                m_pbub     = bub;
            end else begin
                use_idx = bub ? m_last_idx : idx;
                if (m) e_word = aux * 32 + use_idx;
                else   e_word = ((((m_last_cnt - aux) & 127) * 32) + use_idx - m_last_idx) & 4095;
                e_valid    = 1;
                e_bub      = bub | m_pbub;
                m_pbub     = 0;
                m_last_cnt = aux;
                m_last_idx = use_idx;
            end
        end
        if (!e) m_primed = 0;
        p_vld = e;
        p_cnt = c;
        p_ph  = p;
    endfunction

    function automatic logic [15:0] rand_ph(input bit allow_bub);
        int          k;
        logic [31:0] t;
        k = int'($urandom_range(0, 16));
        t = (32'd1 << k) - 32'd1;
        if (allow_bub && $urandom_range(0, 7) == 0) return 16'($urandom);
        return ($urandom_range(0, 1) == 1) ? t[15:0] : ~t[15:0];
    endfunction

    task automatic step(input bit e, input bit m, input int c, input logic [15:0] p);
        @(negedge clk);
        en = e; mode = m; counter_in = 7'(c); phase_in = p;
        @(posedge clk);
        model_edge(e, m, c, p);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; counter_in = '0; phase_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tdc_word !== 12'd0) begin failures++; $display("FAIL reset_word got=%0d exp=0", tdc_word); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        checks++; if (bubble_o !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%0b exp=0", bubble_o); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_differential();
        step(1, 0, 10, 16'h00FF);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL diff_first_valid got=%0b exp=0", valid_o); end
        step(1, 0, 6, 16'h0FFF);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL diff_prime_valid got=%0b exp=0", valid_o); end
        step(0, 0, 0, 16'h0000);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL diff_word_valid got=%0b exp=1", valid_o); end
        checks++; if (tdc_word !== 12'd132) begin failures++; $display("FAIL diff_word got=%0d exp=132", tdc_word); end
        step(0, 0, 0, 16'h0000);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL diff_strobe got=%0b exp=0", valid_o); end
        checks++; if (tdc_word !== 12'd132) begin failures++; $display("FAIL diff_hold got=%0d exp=132", tdc_word); end
    endtask

    task automatic test_decode();
        step(1, 1, 5, 16'h00FF);
        step(1, 1, 20, 16'h0000);
        step(1, 1, 20, 16'hFFFF);
        checks++; if (tdc_word[4:0] !== 5'd31) begin failures++; $display("FAIL dec_zeros got=%0d exp=31", tdc_word[4:0]); end
        step(1, 1, 20, 16'hFF00);
        checks++; if (tdc_word[4:0] !== 5'd15) begin failures++; $display("FAIL dec_ones got=%0d exp=15", tdc_word[4:0]); end
        step(1, 1, 3, 16'h00FF);
        checks++; if (tdc_word[4:0] !== 5'd23) begin failures++; $display("FAIL dec_rise got=%0d exp=23", tdc_word[4:0]); end
        step(0, 1, 0, 16'h0000);
        checks++; if (tdc_word !== 12'h047) begin failures++; $display("FAIL dec_abs got=%0h exp=047", tdc_word); end
    endtask

    task automatic test_wrap();
        step(1, 0, 1, 16'hFF00);
        step(1, 0, 126, 16'hFF00);
        step(1, 0, 0, 16'h00FF);
        checks++; if (tdc_word !== 12'd96) begin failures++; $display("FAIL wrap_diff got=%0d exp=96", tdc_word); end
        step(0, 1, 0, 16'h0000);
        checks++; if (tdc_word !== 12'd4071) begin failures++; $display("FAIL wrap_aux got=%0d exp=4071", tdc_word); end
    endtask

    task automatic test_bubble();
        step(1, 1, 10, 16'h00FF);
        step(1, 1, 10, 16'h00FF);
        step(1, 1, 10, 16'h0F0F);
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL bub_err_before got=%0d exp=0", err_cnt); end
        step(1, 1, 10, 16'h00FF);
        checks++; if (bubble_o !== 1'b1) begin failures++; $display("FAIL bub_flag got=%0b exp=1", bubble_o); end
        checks++; if (tdc_word !== 12'd295) begin failures++; $display("FAIL bub_held_word got=%0d exp=295", tdc_word); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL bub_err_after got=%0d exp=1", err_cnt); end
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 10, 16'h0F0F);
            checks++;
            if (err_cnt !== 8'(m_err)) begin
                failures++; $display("FAIL bub_err_run i=%0d got=%0d exp=%0d", i, err_cnt, m_err);
            end
        end
        checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL bub_saturate got=%0d exp=255", err_cnt); end
        step(0, 1, 0, 16'h0000);
    endtask

    task automatic test_en_gap();
        bit ens [15];
        ens = '{1,1,1,1,1,0,0,0,1,1,1,1,1,1,1};
        for (int i = 0; i < 15; i++) begin
            step(ens[i], 0, int'($urandom_range(0, 127)), rand_ph(0));
            checks++;
            if (valid_o !== e_valid) begin failures++; $display("FAIL gap_valid i=%0d got=%0b exp=%0b", i, valid_o, e_valid); end
            checks++;
            if (tdc_word !== 12'(e_word)) begin failures++; $display("FAIL gap_word i=%0d got=%0d exp=%0d", i, tdc_word, e_word); end
            if (i == 8 || i == 9) begin
                checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL gap_reprime i=%0d got=%0b exp=0", i, valid_o); end
            end
            if (i == 10) begin
                checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL gap_resume got=%0b exp=1", valid_o); end
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (tdc_word !== 12'd0) begin failures++; $display("FAIL arst_word got=%0d exp=0", tdc_word); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0b exp=0", valid_o); end
        checks++; if (bubble_o !== 1'b0) begin failures++; $display("FAIL arst_bubble got=%0b exp=0", bubble_o); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL arst_err got=%0d exp=0", err_cnt); end
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 40, 16'h003F);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL arst_s1 got=%0b exp=0", valid_o); end
        step(1, 0, 37, 16'hFFF0);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL arst_s2 got=%0b exp=0", valid_o); end
        step(0, 0, 0, 16'h0000);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL arst_s3 got=%0b exp=1", valid_o); end
        // cnt 39 -> 37, idx 5 -> 19: (2<<5) + 14 = 78
        checks++; if (tdc_word !== 12'd78) begin failures++; $display("FAIL arst_word_after got=%0d exp=78", tdc_word); end
    endtask

    task automatic test_random();
        bit m;
        m = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) m = bit'($urandom_range(0, 1));
            step(($urandom_range(0, 9) != 0), m, int'($urandom_range(0, 127)), rand_ph(1));
            checks++;
            if (valid_o !== e_valid) begin failures++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, valid_o, e_valid); end
            checks++;
            if (tdc_word !== 12'(e_word)) begin failures++; $display("FAIL rnd_word i=%0d got=%0d exp=%0d", i, tdc_word, e_word); end
            checks++;
            if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL rnd_err i=%0d got=%0d exp=%0d", i, err_cnt, m_err); end
            if (e_valid) begin
                checks++;
                if (bubble_o !== e_bub) begin failures++; $display("FAIL rnd_bubble i=%0d got=%0b exp=%0b", i, bubble_o, e_bub); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_differential();
        test_decode();
        test_wrap();
        test_bubble();
        test_en_gap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
